// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants, state type and helpers for the segment scan reader
package seg_scan_pkg;

  // Bit order matches the encoder: bit6=a ... bit0=g
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - seven-segment pattern to digit value, blank and error flags
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  always_comb begin
    value = DIG_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: begin
        value = DIG_BLANK;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - recovers digit values from a multiplexed seven-segment scan bus
module seg_scan_reader
  import seg_scan_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_en,
  output logic              frame_valid,
  output logic [4*NDIG-1:0] frame_digits,
  output logic [NDIG-1:0]   frame_blank,
  output logic [NDIG-1:0]   frame_err
);

  localparam int            CW      = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]        r_seg;
  logic [NDIG-1:0]   r_en;

  scan_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [6:0]        ref_seg_q, ref_seg_d;
  logic [NDIG-1:0]   ref_en_q, ref_en_d;
  logic              capture;

  logic [NDIG-1:0]   seen_q;
  logic [NDIG-1:0]   seen_base;
  logic              publish;
  logic [4*NDIG-1:0] shadow_digits;
  logic [NDIG-1:0]   shadow_blank;
  logic [NDIG-1:0]   shadow_err;

  logic [3:0]        dec_value;
  logic              dec_blank;
  logic              dec_err;
  logic              en_onehot;
  logic              same;

  seg_pattern_decode u_decode (
    .pattern (r_seg),
    .value   (dec_value),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  assign en_onehot = (r_en != '0) && ((r_en & (r_en - NDIG'(1))) == '0);
  assign same      = (r_seg == ref_seg_q) && (r_en == ref_en_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg     <= '0;
      r_en      <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_seg_q <= '0;
      ref_en_q  <= '0;
    end else begin
      r_seg     <= seg_in;
      r_en      <= dig_en;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_seg_q <= ref_seg_d;
      ref_en_q  <= ref_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_seg_d = ref_seg_q;
    ref_en_d  = ref_en_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_onehot) begin
          state_d   = SETTLE;
          cnt_d     = CW'(1);
          ref_seg_d = r_seg;
          ref_en_d  = r_en;
        end
      end
      SETTLE: begin
        if (same) begin
          // cnt only advances below the limit, so it saturates rather than wraps
          if (cnt_q == CNT_MAX) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (en_onehot) begin
          cnt_d     = CW'(1);
          ref_seg_d = r_seg;
          ref_en_d  = r_en;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!same) begin
          if (en_onehot) begin
            state_d   = SETTLE;
            cnt_d     = CW'(1);
            ref_seg_d = r_seg;
            ref_en_d  = r_en;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full set of seen slots is published on the following edge
  assign publish   = (seen_q == '1);
  assign seen_base = publish ? '0 : seen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q        <= '0;
      shadow_digits <= '0;
      shadow_blank  <= '0;
      shadow_err    <= '0;
      frame_valid   <= 1'b0;
      frame_digits  <= '0;
      frame_blank   <= '0;
      frame_err     <= '0;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        frame_digits <= shadow_digits;
        frame_blank  <= shadow_blank;
        frame_err    <= shadow_err;
      end
      if (capture) begin
        // Revisiting an already-seen slot means the scan wrapped: start a new frame
        if ((seen_base & ref_en_q) != '0) seen_q <= ref_en_q;
        else                              seen_q <= seen_base | ref_en_q;
        for (int i = 0; i < NDIG; i++) begin
          if (ref_en_q[i]) begin
            shadow_digits[4*i +: 4] <= dec_value;
            shadow_blank[i]         <= dec_blank;
            shadow_err[i]           <= dec_err;
          end
        end
      end else begin
        seen_q <= seen_base;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb/tb_seg_scan_reader.sv - directed table-driven bench for seg_scan_reader
module tb_seg_scan_reader;
  import seg_scan_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic        frame_valid;
  logic [15:0] frame_digits;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;

  seg_scan_reader #(.NDIG(4), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .dig_en       (dig_en),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_blank  (frame_blank),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          pulses = 0;
  int          last_pulse_cyc = 0;
  logic [15:0] cap_digits = '0;
  logic [3:0]  cap_blank = '0;
  logic [3:0]  cap_err = '0;
  always @(negedge clk) begin
    if (frame_valid) begin
      pulses         <= pulses + 1;
      last_pulse_cyc <= cyc;
      cap_digits     <= frame_digits;
      cap_blank      <= frame_blank;
      cap_err        <= frame_err;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] seg, input logic [3:0] en, input int n);
    for (int k = 0; k < n; k++) begin
      seg_in = seg;
      dig_en = en;
      @(negedge clk);
    end
  endtask

  task automatic slot(input logic [6:0] seg, input int idx);
    last_start = cyc + 1;
    drive(seg, 4'(1 << idx), 10);
    drive(7'h00, 4'b0000, 2);
  endtask

  task automatic scan(input logic [27:0] pats);
    for (int i = 0; i < 4; i++) slot(pats[7*i +: 7], i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    seg_in = '0;
    dig_en = '0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  typedef struct packed {
    logic [27:0] pats;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs [5];
  int   p0;

  initial begin
    vecs[0] = '{pats: {7'h33, 7'h79, 7'h6D, 7'h30}, digits: 16'h4321, blank: 4'b0000, err: 4'b0000};
    vecs[1] = '{pats: {7'h5F, 7'h73, 7'h7F, 7'h7E}, digits: 16'h6980, blank: 4'b0000, err: 4'b0000};
    vecs[2] = '{pats: {7'h70, 7'h00, 7'h01, 7'h5B}, digits: 16'h7FE5, blank: 4'b0100, err: 4'b0010};
    vecs[3] = '{pats: {7'h79, 7'h33, 7'h5B, 7'h70}, digits: 16'h3457, blank: 4'b0000, err: 4'b0000};
    vecs[4] = '{pats: {7'h12, 7'h7E, 7'h00, 7'h00}, digits: 16'hE0FF, blank: 4'b0011, err: 4'b1000};

    seg_in = '0;
    dig_en = '0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    @(negedge clk);
    check("reset_valid",  32'(frame_valid),  32'h0);
    check("reset_digits", 32'(frame_digits), 32'h0);
    check("reset_blank",  32'(frame_blank),  32'h0);
    check("reset_err",    32'(frame_err),    32'h0);

    for (int v = 0; v < 5; v++) begin
      p0 = pulses;
      scan(vecs[v].pats);
      check($sformatf("v%0d_pulses", v), 32'(pulses - p0), 32'd1);
      check($sformatf("v%0d_latency", v), 32'(last_pulse_cyc), 32'(last_start + 6));
      check($sformatf("v%0d_digits", v), 32'(cap_digits), 32'(vecs[v].digits));
      check($sformatf("v%0d_blank", v), 32'(cap_blank), 32'(vecs[v].blank));
      check($sformatf("v%0d_err", v), 32'(cap_err), 32'(vecs[v].err));
      check($sformatf("v%0d_hold", v), 32'(frame_digits), 32'(vecs[v].digits));
    end

    // Glitches: short 6D before 79 on slot 0, isolated 3-cycle 7F on slot 1
    p0 = pulses;
    drive(7'h6D, 4'b0001, 3);
    drive(7'h79, 4'b0001, 6);
    drive(7'h00, 4'b0000, 2);
    drive(7'h7F, 4'b0010, 3);
    drive(7'h00, 4'b0000, 2);
    slot(7'h30, 1);
    slot(7'h5B, 2);
    slot(7'h70, 3);
    @(negedge clk);
    check("glitch_pulses", 32'(pulses - p0), 32'd1);
    check("glitch_digits", 32'(cap_digits), 32'h7513);

    // Revisit of slot 0 restarts the scan
    p0 = pulses;
    slot(7'h7E, 0);
    slot(7'h30, 1);
    slot(7'h79, 0);
    check("restart_nopulse", 32'(pulses - p0), 32'd0);
    slot(7'h6D, 1);
    slot(7'h33, 2);
    slot(7'h5B, 3);
    @(negedge clk);
    check("restart_pulses", 32'(pulses - p0), 32'd1);
    check("restart_digits", 32'(cap_digits), 32'h5423);

    // Multi-hot ghost window
    p0 = pulses;
    slot(7'h7E, 0);
    drive(7'h30, 4'b0011, 20);
    check("ghost_state", 32'(dut.state_q), 32'(IDLE));
    check("ghost_seen", 32'(dut.seen_q), 32'h1);
    check("ghost_nopulse", 32'(pulses - p0), 32'd0);
    drive(7'h6D, 4'b0010, 2);
    check("ghost_cnt", 32'(dut.cnt_q), 32'd1);
    check("ghost_settle", 32'(dut.state_q), 32'(SETTLE));
    drive(7'h6D, 4'b0010, 8);
    drive(7'h00, 4'b0000, 2);
    slot(7'h70, 2);
    slot(7'h7F, 3);
    @(negedge clk);
    check("ghost_pulses", 32'(pulses - p0), 32'd1);
    check("ghost_digits", 32'(cap_digits), 32'h8720);

    // Reset after a partial scan
    p0 = pulses;
    slot(7'h73, 0);
    slot(7'h7F, 1);
    slot(7'h70, 2);
    check("partial_hold", 32'(frame_digits), 32'h8720);
    check("partial_nopulse", 32'(pulses - p0), 32'd0);
    do_reset();
    check("rst2_valid",  32'(frame_valid),  32'h0);
    check("rst2_digits", 32'(frame_digits), 32'h0);
    check("rst2_blank",  32'(frame_blank),  32'h0);
    check("rst2_err",    32'(frame_err),    32'h0);
    check("rst2_seen",   32'(dut.seen_q),   32'h0);
    slot(7'h30, 3);
    check("rst2_nopulse", 32'(pulses - p0), 32'd0);
    slot(7'h33, 0);
    slot(7'h5B, 1);
    slot(7'h5F, 2);
    @(negedge clk);
    check("rst2_pulses", 32'(pulses - p0), 32'd1);
    check("rst2_frame",  32'(cap_digits),  32'h1654);
    check("rst2_fblank", 32'(cap_blank),   32'h0);
    check("rst2_ferr",   32'(cap_err),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reads a multiplexed N-digit seven-segment display bus (segment lines plus one-hot digit enables) and recovers the displayed digit values. This is the inverse of the team's BCD-to-segment encoder.
- Each digit slot is captured only after its pattern has been stable for a programmable number of cycles.
- A full frame is published, with a one-cycle valid pulse, once every digit has been captured in one scan.
- Used in display loop-back checking and on the self-test path.

Parameters:
- NDIG, 4: number of digit slots on the bus (2..8).
- STABLE_CYCLES, 8: consecutive identical samples required before a slot is captured (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_en  in  NDIG  digit enables, active-high; legal only when one-hot.
- frame_valid  out  1  one-cycle pulse; frame outputs updated this cycle.
- frame_digits  out  4*NDIG  decoded values; slot i occupies bits [4i+3:4i].
- frame_blank  out  NDIG  slot showed all segments off.
- frame_err  out  NDIG  slot showed an illegal pattern.

Behaviour:
- Input stage: seg_in and dig_en are registered once (r_seg, r_en) before any logic.
- Pattern decode (combinational, on r_seg):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9.
  - 00 → value 4'hF, blank=1.
  - Any other pattern → value 4'hE, err=1.
- State machine: states IDLE, SETTLE, HOLD.
  - IDLE: stays while r_en is not one-hot (all-zero or multi-hot = blanking/ghost interval). When r_en is one-hot, go to SETTLE with cnt=1 and latch ref_seg/ref_en.
  - SETTLE: if r_seg==ref_seg and r_en==ref_en, cnt increments. When cnt==STABLE_CYCLES, capture the slot and go to HOLD.
  - SETTLE: if r_seg/r_en change and r_en is still one-hot, restart SETTLE with cnt=1 and new refs. If r_en is not one-hot, go to IDLE.
  - SETTLE with STABLE_CYCLES=1: capture occurs on the SETTLE-entry cycle's successor; cnt starts at 1, so the compare is immediate.
  - HOLD: stay while r_seg==ref_seg and r_en==ref_en. On any change, go to IDLE if r_en is not one-hot; otherwise go to SETTLE with cnt=1.
- Capture of slot i (i = index of the set bit in ref_en): write the decoded value, blank and err into the shadow registers for slot i, and set seen[i].
  - If seen[i] is already 1 at capture, the scan restarted: clear seen, then set only seen[i], and overwrite slot i.
- Frame publish: on the cycle after a capture makes seen all-ones:
  - copy shadow registers to frame_digits/blank/err;
  - pulse frame_valid for exactly 1 cycle;
  - clear seen.
- Frame outputs hold their values between publishes.
- Latency: a pattern first presented at the input on edge k is captured at edge k+1+STABLE_CYCLES. frame_valid follows 1 cycle after the final slot's capture.
- cnt saturates at STABLE_CYCLES and never wraps.
- Reset:
  - frame_valid=0, frame_digits=0, frame_blank=0, frame_err=0.
  - seen=0, shadow=0, cnt=0, state=IDLE, r_seg=0, r_en=0.
  - Reset asserted mid-settle or mid-frame discards all partial captures; the first frame after reset requires a complete fresh scan.
- If reset and a capture coincide, reset wins.

Decomposition:
- Package seg_scan_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK, in the same bit order as the encoder;
  - codes DIG_BLANK=4'hF and DIG_ERR=4'hE;
  - state enum (IDLE, SETTLE, HOLD);
  - counter width function clog2(STABLE_CYCLES+1).
- Sub-module seg_pattern_decode: purely combinational, 7-bit pattern in → value[3:0], blank, err out. Shared with the display self-test checker.

Test Plan (NDIG=4, STABLE_CYCLES=4):
1. Scan digits 1,2,3,4 (patterns 30,6D,79,33) on dig_en 0001..1000, each held 10 cycles with 2 all-zero gap cycles. Required: one frame_valid pulse 1 cycle after slot 3 capture; frame_digits=16'h4321; blank=0; err=0.
2. Slot 0 shows 6D for 3 cycles, then 79 for 6 cycles. Required: captured value is 3, not 2. A 3-cycle glitch on any slot is never captured.
3. Slot 2 shows 00 and slot 1 shows 01, others legal digits. Required: frame_blank=4'b0100, frame_err=4'b0010, nibbles 2 and 1 are F and E.
4. Capture slots 0,1, then slot 0 again, then slots 1,2,3. Required: no pulse until slot 3; a single frame containing the second slot-0 value.
5. dig_en=0011 held 20 cycles between legal slots. Required: no capture during that window; state returns to IDLE; cnt restarts at 1.
6. Assert reset for 1 cycle after capturing slots 0-2. Required: all outputs 0. The next frame_valid arrives only after all 4 slots are recaptured.
